rm_stage_report_unit: RTL

- Parametrised successor of the fixed cluster stage in the runtime monitor.
- Forwards the symbol stream to the next stage through a run-gated pipeline register.
- Captures the report wires of NUM_CH LTL automata, each with REP_PER_CH reports, into a timestamped report FIFO.
- Serialises captured reports into one-event-per-transfer valid/ready records for the downstream report collector.

---
 rtl/rm_stage_report_unit.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/rm_stage_report_unit.sv
// Runtime-monitor stage: run-gated symbol pipeline plus timestamped capture and
// serialisation of automata reports. Define RM_STICKY_REPORT_EN for sticky_rep.
module rm_stage_report_unit #(
  parameter int SYM_W      = 8,
  parameter int NUM_CH     = 7,
  parameter int REP_PER_CH = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_W       = 16,
  parameter int DROP_W     = 8,
  localparam int REP_W     = NUM_CH * REP_PER_CH,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int RI_W      = (REP_PER_CH > 1) ? $clog2(REP_PER_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic              sym_reset,
  input  logic [SYM_W-1:0]  symbols_in,
  input  logic [REP_W-1:0]  report_in,
  output logic [SYM_W-1:0]  out_symbols,
  output logic              out_reset,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CH_W-1:0]   evt_ch,
  output logic [RI_W-1:0]   evt_rep,
  output logic [TS_W-1:0]   evt_ts,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt,
  input  logic              clr_ovf,
  output logic [REP_W-1:0]  sticky_rep,
  input  logic              clr_sticky
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int ENT_W = REP_W + TS_W;

  typedef enum logic {S_IDLE, S_EMIT} ser_state_t;

  logic [SYM_W-1:0]  out_symbols_q, out_symbols_d;
  logic              out_reset_q, out_reset_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [ENT_W-1:0]  rd_data;
  logic [REP_W-1:0]  rd_vec;
  logic              fifo_empty, fifo_full;
  logic              cap_req, pop, wr_en, drop;

  ser_state_t        state_q;
  logic [REP_W-1:0]  work_vec_q;
  logic [REP_W-1:0]  next_vec;
  logic              evt_valid_q;
  logic [CH_W-1:0]   evt_ch_q;
  logic [RI_W-1:0]   evt_rep_q;
  logic [TS_W-1:0]   evt_ts_q;

  // Channel/report index of the lowest set bit; descending scan lets the lowest win.
  function automatic logic [CH_W+RI_W-1:0] lowest_ch_rep(input logic [REP_W-1:0] v);
    logic [CH_W-1:0] ch;
    logic [RI_W-1:0] rep;
    ch  = '0;
    rep = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      for (int r = REP_PER_CH - 1; r >= 0; r--) begin
        if (v[c*REP_PER_CH + r]) begin
          ch  = CH_W'(c);
          rep = RI_W'(r);
        end
      end
    end
    return {ch, rep};
  endfunction

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data    = fifo_mem[rd_ptr_q[AW-1:0]];
  assign rd_vec     = rd_data[ENT_W-1:TS_W];

  assign cap_req = run && (report_in != '0);
  assign pop     = (state_q == S_IDLE) && !fifo_empty;
  // A full FIFO still accepts when the serializer frees a slot on the same edge.
  assign wr_en   = cap_req && (!fifo_full || pop);
  assign drop    = cap_req && fifo_full && !pop;

  assign next_vec = work_vec_q & (work_vec_q - REP_W'(1));

  always_comb begin
    out_symbols_d = out_symbols_q;
    out_reset_d   = out_reset_q;
    ts_d          = ts_q;
    if (run) begin
      out_symbols_d = symbols_in;
      out_reset_d   = sym_reset;
      ts_d          = sym_reset ? '0 : ts_q + TS_W'(1);
    end

    wr_ptr_d = wr_ptr_q + (AW+1)'(wr_en);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);

    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clr_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (clr_ovf)
        drop_cnt_d = DROP_W'(1);
      else if (drop_cnt_q != {DROP_W{1'b1}})
        drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_symbols_q <= '0;
      out_reset_q   <= 1'b0;
      ts_q          <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      overflow_q    <= 1'b0;
      drop_cnt_q    <= '0;
    end else begin
      out_symbols_q <= out_symbols_d;
      out_reset_q   <= out_reset_d;
      ts_q          <= ts_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      overflow_q    <= overflow_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // Storage array carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en)
      fifo_mem[wr_ptr_q[AW-1:0]] <= {report_in, ts_q};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      work_vec_q  <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_rep_q   <= '0;
      evt_ts_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            work_vec_q             <= rd_vec;
            evt_ts_q               <= rd_data[TS_W-1:0];
            {evt_ch_q, evt_rep_q}  <= lowest_ch_rep(rd_vec);
            evt_valid_q            <= 1'b1;
            state_q                <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (evt_ready) begin
            work_vec_q <= next_vec;
            if (next_vec == '0) begin
              evt_valid_q <= 1'b0;
              state_q     <= S_IDLE;
            end else begin
              {evt_ch_q, evt_rep_q} <= lowest_ch_rep(next_vec);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef RM_STICKY_REPORT_EN
  logic [REP_W-1:0] sticky_q, sticky_d;

  // New reports are OR-ed in after the clear, so a same-edge set survives.
  always_comb begin
    sticky_d = clr_sticky ? '0 : sticky_q;
    if (run)
      sticky_d = sticky_d | report_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      sticky_q <= '0;
    else
      sticky_q <= sticky_d;
  end

  assign sticky_rep = sticky_q;
`else
  logic unused_clr_sticky;
  assign unused_clr_sticky = clr_sticky;
  assign sticky_rep        = '0;
`endif

  assign out_symbols = out_symbols_q;
  assign out_reset   = out_reset_q;
  assign evt_valid   = evt_valid_q;
  assign evt_ch      = evt_ch_q;
  assign evt_rep     = evt_rep_q;
  assign evt_ts      = evt_ts_q;
  assign overflow    = overflow_q;
  assign drop_cnt    = drop_cnt_q;

endmodule
